// File: rtl/phy_rx_deframer_pkg.sv
// Shared symbol codes, state/ordered-set encodings and classifier helpers
// for the PHY receive deframer. The same code points are used by the TX mux.
package phy_rx_deframer_pkg;

  // K-symbol code points
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] SYM_FTS = 8'h3C;
  localparam logic [7:0] SYM_COM = 8'hBC;

  // Deframer states
  typedef enum logic [1:0] {
    ST_LINK = 2'd0,
    ST_OS   = 2'd1,
    ST_PKT  = 2'd2
  } state_e;

  // Ordered-set type as reported on OS_TYPE
  typedef enum logic [1:0] {
    OS_SKP = 2'b00,
    OS_IDL = 2'b01,
    OS_FTS = 2'b10
  } os_type_e;

  // Symbol classes produced by the classifier
  typedef enum logic [3:0] {
    SC_IDLE = 4'd0,   // data 8'h00, logical idle
    SC_DATA = 4'd1,   // any other data byte
    SC_STP  = 4'd2,
    SC_SDP  = 4'd3,
    SC_END  = 4'd4,
    SC_EDB  = 4'd5,
    SC_COM  = 4'd6,
    SC_SKP  = 4'd7,
    SC_IDL  = 4'd8,
    SC_FTS  = 4'd9,
    SC_KBAD = 4'd10   // K symbol with an unknown code
  } sym_class_e;

  // True for the K codes that may follow COM inside an ordered set
  function automatic logic is_os_code(input sym_class_e c);
    return (c == SC_SKP) || (c == SC_IDL) || (c == SC_FTS);
  endfunction

  // Map an ordered-set body symbol class to its OS_TYPE encoding
  function automatic os_type_e os_type_of(input sym_class_e c);
    os_type_e t;
    case (c)
      SC_IDL:  t = OS_IDL;
      SC_FTS:  t = OS_FTS;
      default: t = OS_SKP;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/phy_rx_deframer_kclass.sv
// Combinational symbol classifier: {data, k} -> symbol class code.
module phy_rx_kclass
  import phy_rx_deframer_pkg::*;
(
  input  logic [7:0] data_in,
  input  logic       k_in,
  output sym_class_e sym_class
);

  // Decode the received symbol into one class
  always_comb begin
    sym_class = SC_DATA;
    if (!k_in) begin
      if (data_in == 8'h00) sym_class = SC_IDLE;
    end else begin
      case (data_in)
        SYM_STP: sym_class = SC_STP;
        SYM_SDP: sym_class = SC_SDP;
        SYM_END: sym_class = SC_END;
        SYM_EDB: sym_class = SC_EDB;
        SYM_COM: sym_class = SC_COM;
        SYM_SKP: sym_class = SC_SKP;
        SYM_IDL: sym_class = SC_IDL;
        SYM_FTS: sym_class = SC_FTS;
        default: sym_class = SC_KBAD;
      endcase
    end
  end

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive-side symbol deframer: splits the descrambled byte/K stream into
// packet payload, ordered sets and framing errors. One symbol per CLK0,
// every output registered one cycle after its symbol is sampled.
// Optional error counter enabled by defining PHY_RX_ERR_COUNT_EN.
//
// Stream semantics: there is no backpressure. D_OUT is meaningful only in a
// cycle where D_VALID is 1; all *_START/*_END/*_VALID/ERR outputs are
// single-cycle pulses. PKT_TYPE and OS_TYPE hold between their pulses.
module phy_rx_deframer
  import phy_rx_deframer_pkg::*;
#(
  parameter int OS_LEN        = 4,
  parameter int MAX_PKT_BYTES = 1024
) (
  input  logic        CLK0,
  input  logic        RESET,
  input  logic [7:0]  DATA_IN,
  input  logic        K_IN,
  output logic [7:0]  D_OUT,
  output logic        D_VALID,
  output logic        PKT_START,
  output logic        PKT_TYPE,
  output logic        PKT_END,
  output logic        PKT_NULL,
  output logic        OS_VALID,
  output logic [1:0]  OS_TYPE,
  output logic        ERR,
  output logic [15:0] ERR_CNT,
  output logic [1:0]  DBG_STATE
);

  localparam int OS_CW = $clog2(OS_LEN + 1);
  localparam int BCW   = $clog2(MAX_PKT_BYTES + 1);

  sym_class_e sym_class;

  phy_rx_kclass u_kclass (
    .data_in   (DATA_IN),
    .k_in      (K_IN),
    .sym_class (sym_class)
  );

  state_e           state_q,     state_d;
  logic [OS_CW-1:0] os_cnt_q,    os_cnt_d;
  os_type_e         os_code_q,   os_code_d;
  logic [BCW-1:0]   byte_cnt_q,  byte_cnt_d;
  logic [7:0]       d_out_q,     d_out_d;
  logic             d_valid_q,   d_valid_d;
  logic             pkt_start_q, pkt_start_d;
  logic             pkt_type_q,  pkt_type_d;
  logic             pkt_end_q,   pkt_end_d;
  logic             pkt_null_q,  pkt_null_d;
  logic             os_valid_q,  os_valid_d;
  os_type_e         os_type_q,   os_type_d;
  logic             err_q,       err_d;

  // Next-state and next-output decode for the current symbol
  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    os_code_d   = os_code_q;
    byte_cnt_d  = byte_cnt_q;
    d_out_d     = d_out_q;
    d_valid_d   = 1'b0;
    pkt_start_d = 1'b0;
    pkt_type_d  = pkt_type_q;
    pkt_end_d   = 1'b0;
    pkt_null_d  = 1'b0;
    os_valid_d  = 1'b0;
    os_type_d   = os_type_q;
    err_d       = 1'b0;

    case (state_q)
      ST_LINK: begin
        case (sym_class)
          SC_IDLE: ;
          SC_COM: begin
            state_d  = ST_OS;
            os_cnt_d = OS_CW'(1);
          end
          SC_STP, SC_SDP: begin
            state_d     = ST_PKT;
            pkt_start_d = 1'b1;
            pkt_type_d  = (sym_class == SC_SDP);
            byte_cnt_d  = '0;
          end
          default: err_d = 1'b1;
        endcase
      end

      ST_OS: begin
        if (sym_class == SC_COM) begin
          // A fresh COM restarts the set without flagging an error
          os_cnt_d = OS_CW'(1);
        end else if (is_os_code(sym_class) &&
                     ((os_cnt_q == OS_CW'(1)) || (os_type_of(sym_class) == os_code_q))) begin
          os_code_d = os_type_of(sym_class);
          if (os_cnt_q == OS_CW'(OS_LEN - 1)) begin
            os_valid_d = 1'b1;
            os_type_d  = os_type_of(sym_class);
            state_d    = ST_LINK;
          end else begin
            os_cnt_d = os_cnt_q + OS_CW'(1);
          end
        end else begin
          err_d   = 1'b1;
          state_d = ST_LINK;
        end
      end

      ST_PKT: begin
        case (sym_class)
          SC_IDLE, SC_DATA: begin
            if (byte_cnt_q == BCW'(MAX_PKT_BYTES)) begin
              // Oversize packet: drop the byte and abort
              err_d      = 1'b1;
              pkt_end_d  = 1'b1;
              pkt_null_d = 1'b1;
              state_d    = ST_LINK;
            end else begin
              d_out_d    = DATA_IN;
              d_valid_d  = 1'b1;
              byte_cnt_d = byte_cnt_q + BCW'(1);
            end
          end
          SC_END: begin
            pkt_end_d = 1'b1;
            state_d   = ST_LINK;
          end
          SC_EDB: begin
            pkt_end_d  = 1'b1;
            pkt_null_d = 1'b1;
            state_d    = ST_LINK;
          end
          SC_COM: begin
            err_d      = 1'b1;
            pkt_end_d  = 1'b1;
            pkt_null_d = 1'b1;
            state_d    = ST_OS;
            os_cnt_d   = OS_CW'(1);
          end
          default: begin
            err_d      = 1'b1;
            pkt_end_d  = 1'b1;
            pkt_null_d = 1'b1;
            state_d    = ST_LINK;
          end
        endcase
      end

      default: state_d = ST_LINK;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CLK0) begin
    if (RESET) begin
      state_q     <= ST_LINK;
      os_cnt_q    <= '0;
      os_code_q   <= OS_SKP;
      byte_cnt_q  <= '0;
      d_out_q     <= 8'h00;
      d_valid_q   <= 1'b0;
      pkt_start_q <= 1'b0;
      pkt_type_q  <= 1'b0;
      pkt_end_q   <= 1'b0;
      pkt_null_q  <= 1'b0;
      os_valid_q  <= 1'b0;
      os_type_q   <= OS_SKP;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      os_code_q   <= os_code_d;
      byte_cnt_q  <= byte_cnt_d;
      d_out_q     <= d_out_d;
      d_valid_q   <= d_valid_d;
      pkt_start_q <= pkt_start_d;
      pkt_type_q  <= pkt_type_d;
      pkt_end_q   <= pkt_end_d;
      pkt_null_q  <= pkt_null_d;
      os_valid_q  <= os_valid_d;
      os_type_q   <= os_type_d;
      err_q       <= err_d;
    end
  end

`ifdef PHY_RX_ERR_COUNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of ERR pulses, updated alongside ERR
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register
  always_ff @(posedge CLK0) begin
    if (RESET) err_cnt_q <= 16'h0000;
    else       err_cnt_q <= err_cnt_d;
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = 16'h0000;
`endif

  assign D_OUT     = d_out_q;
  assign D_VALID   = d_valid_q;
  assign PKT_START = pkt_start_q;
  assign PKT_TYPE  = pkt_type_q;
  assign PKT_END   = pkt_end_q;
  assign PKT_NULL  = pkt_null_q;
  assign OS_VALID  = os_valid_q;
  assign OS_TYPE   = os_type_q;
  assign ERR       = err_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Directed bench for phy_rx_deframer (OS_LEN=4, MAX_PKT_BYTES=4).
// Expected ERR_CNT follows PHY_RX_ERR_COUNT_EN when it is defined.
module tb_phy_rx_deframer;

  logic        clk0;
  logic        reset;
  logic [7:0]  data_in;
  logic        k_in;
  logic [7:0]  d_out;
  logic        d_valid;
  logic        pkt_start;
  logic        pkt_type;
  logic        pkt_end;
  logic        pkt_null;
  logic        os_valid;
  logic [1:0]  os_type;
  logic        err;
  logic [15:0] err_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  logic [7:0] exp_q[$];

  phy_rx_deframer #(
    .OS_LEN        (4),
    .MAX_PKT_BYTES (4)
  ) dut (
    .CLK0      (clk0),
    .RESET     (reset),
    .DATA_IN   (data_in),
    .K_IN      (k_in),
    .D_OUT     (d_out),
    .D_VALID   (d_valid),
    .PKT_START (pkt_start),
    .PKT_TYPE  (pkt_type),
    .PKT_END   (pkt_end),
    .PKT_NULL  (pkt_null),
    .OS_VALID  (os_valid),
    .OS_TYPE   (os_type),
    .ERR       (err),
    .ERR_CNT   (err_cnt),
    .DBG_STATE (dbg_state)
  );

  // Clock and initial reset level
  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] exp_err_cnt();
`ifdef PHY_RX_ERR_COUNT_EN
    return 16'(exp_err);
`else
    return 16'h0000;
`endif
  endfunction

  // Drive one symbol and check the pulse vector {D_VALID,PKT_START,PKT_END,PKT_NULL,OS_VALID,ERR}
  task automatic step(input string tag, input logic k, input logic [7:0] d, input logic [5:0] exp_p);
    @(negedge clk0);
    k_in    = k;
    data_in = d;
    @(posedge clk0);
    #1;
    if (exp_p[0]) exp_err++;
    chk({tag, "_pulses"}, {10'd0, d_valid, pkt_start, pkt_end, pkt_null, os_valid, err}, {10'd0, exp_p});
    chk({tag, "_errcnt"}, err_cnt, exp_err_cnt());
  endtask

  // Apply reset for n cycles and check every output is cleared
  task automatic do_reset(input string tag, input int n, input logic k, input logic [7:0] d);
    @(negedge clk0);
    reset   = 1'b1;
    k_in    = k;
    data_in = d;
    repeat (n) @(posedge clk0);
    #1;
    exp_err = 0;
    chk({tag, "_outs"}, {6'd0, d_out, d_valid, pkt_start, pkt_type, pkt_end, pkt_null, os_valid}, 16'd0);
    chk({tag, "_os_err"}, {13'd0, os_type, err}, 16'd0);
    chk({tag, "_errcnt"}, err_cnt, 16'd0);
    chk({tag, "_state"}, {14'd0, dbg_state}, 16'd0);
    @(negedge clk0);
    reset   = 1'b0;
    k_in    = 1'b0;
    data_in = 8'h00;
  endtask

  // Scoreboard: every accepted payload byte must match the next expected byte
  always @(posedge clk0) begin
    #1;
    if (d_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_byte", {8'd0, d_out}, 16'hFFFF);
      end else begin
        chk("sb_byte", {8'd0, d_out}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  // Directed stimulus
  initial begin
    reset   = 1'b1;
    k_in    = 1'b0;
    data_in = 8'h00;
    do_reset("reset0", 2, 1'b0, 8'h00);

    // 1: SKP ordered set
    step("t1_com", 1'b1, 8'hBC, 6'b000000);
    step("t1_skp1", 1'b1, 8'h1C, 6'b000000);
    step("t1_skp2", 1'b1, 8'h1C, 6'b000000);
    step("t1_skp3", 1'b1, 8'h1C, 6'b000010);
    chk("t1_os_type", {14'd0, os_type}, 16'd0);
    chk("t1_state", {14'd0, dbg_state}, 16'd0);
    step("link_idle", 1'b0, 8'h00, 6'b000000);

    // 2: TLP with three bytes
    step("t2_stp", 1'b1, 8'hFB, 6'b010000);
    chk("t2_type", {15'd0, pkt_type}, 16'd0);
    exp_q.push_back(8'h55);
    step("t2_d0", 1'b0, 8'h55, 6'b100000);
    exp_q.push_back(8'hFF);
    step("t2_d1", 1'b0, 8'hFF, 6'b100000);
    exp_q.push_back(8'h0F);
    step("t2_d2", 1'b0, 8'h0F, 6'b100000);
    step("t2_end", 1'b1, 8'hFD, 6'b001000);

    // 3: DLLP nullified by EDB
    step("t3_sdp", 1'b1, 8'h5C, 6'b010000);
    chk("t3_type", {15'd0, pkt_type}, 16'd1);
    exp_q.push_back(8'hAA);
    step("t3_d0", 1'b0, 8'hAA, 6'b100000);
    step("t3_edb", 1'b1, 8'hFE, 6'b001100);
    chk("t3_type_hold", {15'd0, pkt_type}, 16'd1);

    // 4: COM aborts a packet and starts an IDL set
    step("t4_stp", 1'b1, 8'hFB, 6'b010000);
    exp_q.push_back(8'h11);
    step("t4_d0", 1'b0, 8'h11, 6'b100000);
    step("t4_com", 1'b1, 8'hBC, 6'b001101);
    chk("t4_state_os", {14'd0, dbg_state}, 16'd1);
    step("t4_idl1", 1'b1, 8'h7C, 6'b000000);
    step("t4_idl2", 1'b1, 8'h7C, 6'b000000);
    step("t4_idl3", 1'b1, 8'h7C, 6'b000010);
    chk("t4_os_type", {14'd0, os_type}, 16'd1);

    // 5: oversize packet, then idle and stray data in LINK
    step("t5_stp", 1'b1, 8'hFB, 6'b010000);
    exp_q.push_back(8'h01);
    step("t5_d0", 1'b0, 8'h01, 6'b100000);
    exp_q.push_back(8'h02);
    step("t5_d1", 1'b0, 8'h02, 6'b100000);
    exp_q.push_back(8'h03);
    step("t5_d2", 1'b0, 8'h03, 6'b100000);
    exp_q.push_back(8'h04);
    step("t5_d3", 1'b0, 8'h04, 6'b100000);
    step("t5_d4_drop", 1'b0, 8'h05, 6'b001101);
    step("t5_idle", 1'b0, 8'h00, 6'b000000);
    step("t5_stray", 1'b0, 8'h33, 6'b000001);

    // OS mismatch, then COM restart into an FTS set
    step("os_com", 1'b1, 8'hBC, 6'b000000);
    step("os_skp", 1'b1, 8'h1C, 6'b000000);
    step("os_mismatch", 1'b1, 8'h7C, 6'b000001);
    chk("os_mismatch_state", {14'd0, dbg_state}, 16'd0);
    step("rs_com", 1'b1, 8'hBC, 6'b000000);
    step("rs_fts", 1'b1, 8'h3C, 6'b000000);
    step("rs_com2", 1'b1, 8'hBC, 6'b000000);
    step("rs_fts1", 1'b1, 8'h3C, 6'b000000);
    step("rs_fts2", 1'b1, 8'h3C, 6'b000000);
    step("rs_fts3", 1'b1, 8'h3C, 6'b000010);
    chk("rs_os_type", {14'd0, os_type}, 16'd2);
    step("link_bad_k", 1'b1, 8'hFD, 6'b000001);

    // Empty packet
    step("e_stp", 1'b1, 8'hFB, 6'b010000);
    step("e_end", 1'b1, 8'hFD, 6'b001000);

    // 6: reset mid-packet, END presented during reset must be ignored
    step("t6_sdp", 1'b1, 8'h5C, 6'b010000);
    exp_q.push_back(8'h22);
    step("t6_d0", 1'b0, 8'h22, 6'b100000);
    do_reset("t6_reset", 1, 1'b1, 8'hFD);
    step("t6_idle", 1'b0, 8'h00, 6'b000000);
    step("t6_stp", 1'b1, 8'hFB, 6'b010000);
    step("t6_end", 1'b1, 8'hFD, 6'b001000);
    step("t6_err1", 1'b0, 8'h33, 6'b000001);
    step("t6_err2", 1'b0, 8'h44, 6'b000001);
    step("t6_err3", 1'b1, 8'h1C, 6'b000001);
`ifdef PHY_RX_ERR_COUNT_EN
    chk("t6_errcnt3", err_cnt, 16'd3);
`else
    chk("t6_errcnt_tied", err_cnt, 16'd0);
`endif

    @(negedge clk0);
    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
